// File: rtl/additive_scrambler_par.sv
// Parallel additive scrambler/descrambler: XORs DATA_W bits per beat with a Fibonacci
// LFSR keystream, with seed load, periodic auto-reseed, bypass and a registered output stage.
module additive_scrambler_par #(
   parameter int                DATA_W    = 8,
   parameter int                LFSR_W    = 7,
   parameter logic [LFSR_W-1:0] POLY      = 7'h60,
   parameter logic [LFSR_W-1:0] SEED      = 7'h7F,
   parameter int                FRAME_LEN = 0
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              bypass_i,
   input  logic              seed_load_i,
   input  logic [LFSR_W-1:0] seed_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              sof_o
);

   localparam int CNT_W = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);

   logic [LFSR_W-1:0] r_lfsr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_first;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_sof;

   logic [LFSR_W-1:0] w_seedVal;
   logic [LFSR_W-1:0] w_startState;
   logic [LFSR_W-1:0] w_step;
   logic [LFSR_W-1:0] w_advState;
   logic [DATA_W-1:0] w_key;
   logic [DATA_W-1:0] w_y;
   logic [CNT_W-1:0]  w_cntInc;
   logic              w_accept;
   logic              w_frameEnd;

   // A same-cycle seed load takes effect before the beat, so the keystream starts from the new seed.
   always_comb begin
      w_seedVal    = (seed_i == '0) ? SEED : seed_i;
      w_startState = seed_load_i ? w_seedVal : r_lfsr;
      w_step       = w_startState;
      w_key        = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_key[i] = w_step[LFSR_W-1];
         w_step   = {w_step[LFSR_W-2:0], ^(w_step & POLY)};
      end
      w_advState = w_step;
   end

   assign ready_o    = ~r_valid | ready_i;
   assign w_accept   = valid_i & ready_o;
   assign w_y        = bypass_i ? data_i : (data_i ^ w_key);
   assign w_cntInc   = r_cnt + CNT_W'(1);
   assign w_frameEnd = (FRAME_LEN > 0) && (w_cntInc == FRAME_LAST);

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_lfsr  <= SEED;
         r_cnt   <= '0;
         r_first <= 1'b1;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
      end else begin
         if (seed_load_i) begin
            r_lfsr  <= w_accept ? w_advState : w_seedVal;
            r_cnt   <= '0;
            r_first <= 1'b1;
         end else if (w_accept) begin
            if (w_frameEnd) begin
               r_lfsr  <= SEED;
               r_cnt   <= '0;
               r_first <= 1'b1;
            end else begin
               r_lfsr  <= w_advState;
               r_cnt   <= w_cntInc;
               r_first <= 1'b0;
            end
         end

         // Output register only empties when downstream takes the beat and nothing replaces it.
         if (w_accept) begin
            r_data  <= w_y;
            r_valid <= 1'b1;
            r_sof   <= r_first | seed_load_i;
         end else if (ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;
   assign sof_o   = r_sof;

endmodule

// File: tb/tb_additive_scrambler_par.sv
// Bench for additive_scrambler_par: directed vector table, stall/reset and frame sequences,
// and a randomized TX->RX chain checked against a keystream recurrence model.
module tb_additive_scrambler_par;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Unit A: default parameters, fully driven by the directed tests
   logic [7:0] a_data_i = '0, a_data_o;
   logic       a_valid_i = 1'b0, a_ready_o, a_bypass_i = 1'b0, a_seed_load_i = 1'b0;
   logic [6:0] a_seed_i = '0;
   logic       a_valid_o, a_ready_i = 1'b1, a_sof_o;

   // Unit B: FRAME_LEN=2
   logic [7:0] b_data_i = '0, b_data_o;
   logic       b_valid_i = 1'b0, b_ready_o, b_valid_o, b_ready_i = 1'b1, b_sof_o;

   // Units C (TX) and D (RX) chained
   logic [7:0] c_data_i = '0, c_data_o, d_data_o;
   logic       c_valid_i = 1'b0, c_ready_o, c_valid_o, c_sof_o;
   logic       d_ready_o, d_valid_o, d_ready_i = 1'b1, d_sof_o;

   additive_scrambler_par dutA (
      .clk_i(clk), .rstn_i(rstn), .data_i(a_data_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
      .bypass_i(a_bypass_i), .seed_load_i(a_seed_load_i), .seed_i(a_seed_i),
      .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i), .sof_o(a_sof_o));

   additive_scrambler_par #(.FRAME_LEN(2)) dutB (
      .clk_i(clk), .rstn_i(rstn), .data_i(b_data_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
      .bypass_i(1'b0), .seed_load_i(1'b0), .seed_i(7'h00),
      .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i), .sof_o(b_sof_o));

   additive_scrambler_par dutC (
      .clk_i(clk), .rstn_i(rstn), .data_i(c_data_i), .valid_i(c_valid_i), .ready_o(c_ready_o),
      .bypass_i(1'b0), .seed_load_i(1'b0), .seed_i(7'h00),
      .data_o(c_data_o), .valid_o(c_valid_o), .ready_i(d_ready_o), .sof_o(c_sof_o));

   additive_scrambler_par dutD (
      .clk_i(clk), .rstn_i(rstn), .data_i(c_data_o), .valid_i(c_valid_o), .ready_o(d_ready_o),
      .bypass_i(1'b0), .seed_load_i(1'b0), .seed_i(7'h00),
      .data_o(d_data_o), .valid_o(d_valid_o), .ready_i(d_ready_i), .sof_o(d_sof_o));

   typedef struct {
      logic [7:0] data;
      bit         byp;
      bit         sl;
      logic [6:0] seed;
      logic [7:0] expData;
      bit         expSof;
      bit         chkSof;
   } vec_t;

   typedef struct packed {
      logic [7:0] y;
      logic       sof;
   } exp_t;

   // Keystream bits b0..b14 from a state: b0..b6 are the state read MSB first,
   // and the taps x^7+x^6+1 give the recurrence b[n+7] = b[n] ^ b[n+1].
   function automatic logic [14:0] modelStream(input logic [6:0] st);
      logic [14:0] b;
      b = '0;
      for (int j = 0; j < 7; j++) b[j] = st[6-j];
      for (int n = 0; n < 8; n++) b[n+7] = b[n] ^ b[n+1];
      return b;
   endfunction

   function automatic logic [6:0] modelNext(input logic [6:0] st);
      logic [14:0] b;
      logic [6:0]  ns;
      b = modelStream(st);
      for (int j = 0; j < 7; j++) ns[6-j] = b[8+j];
      return ns;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input bit byp, input bit sl, input logic [6:0] s);
      a_data_i      = d;
      a_bypass_i    = byp;
      a_seed_load_i = sl;
      a_seed_i      = s;
      a_valid_i     = 1'b1;
      a_ready_i     = 1'b1;
      @(posedge clk);
      #1;
      a_valid_i     = 1'b0;
      a_bypass_i    = 1'b0;
      a_seed_load_i = 1'b0;
   endtask

   task automatic doReset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   vec_t vecs[12];
   logic [7:0] frameExp[4];
   bit         frameSof[4];

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0]  = '{8'h00, 0, 0, 7'h00, 8'h7F, 1, 1};
      vecs[1]  = '{8'h00, 0, 0, 7'h00, 8'h20, 0, 1};
      vecs[2]  = '{8'hFF, 0, 0, 7'h00, 8'hE7, 0, 1};
      vecs[3]  = '{8'hA5, 1, 0, 7'h00, 8'hA5, 0, 1};
      vecs[4]  = '{8'h00, 0, 1, 7'h00, 8'h7F, 1, 1};
      vecs[5]  = '{8'h00, 0, 0, 7'h00, 8'h20, 0, 0};
      vecs[6]  = '{8'h12, 0, 0, 7'h00, 8'h0A, 0, 1};
      vecs[7]  = '{8'h3C, 0, 1, 7'h7F, 8'h43, 1, 1};
      vecs[8]  = '{8'h00, 0, 0, 7'h00, 8'h20, 0, 0};
      vecs[9]  = '{8'hA5, 1, 1, 7'h7F, 8'hA5, 1, 1};
      vecs[10] = '{8'h00, 0, 0, 7'h00, 8'h20, 0, 0};
      vecs[11] = '{8'h00, 0, 0, 7'h00, 8'h18, 0, 1};
      frameExp = '{8'h7F, 8'h20, 8'h7F, 8'h20};
      frameSof = '{1, 0, 1, 0};

      // Reset values, sampled while reset is still asserted
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstValid", a_valid_o, 0);
      checkOutput("rstData", a_data_o, 0);
      checkOutput("rstSof", a_sof_o, 0);
      checkOutput("rstReady", a_ready_o, 1);
      rstn = 1'b1;

      // Stall: held beat stays stable, keystream resumes without skipping
      applyStimulus(8'h00, 0, 0, 7'h00);
      checkOutput("stallFirstData", a_data_o, 8'h7F);
      a_ready_i = 1'b0;
      a_valid_i = 1'b1;
      a_data_i  = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stallReady", a_ready_o, 0);
         checkOutput("stallValid", a_valid_o, 1);
         checkOutput("stallData", a_data_o, 8'h7F);
         checkOutput("stallSof", a_sof_o, 1);
      end
      a_ready_i = 1'b1;
      @(posedge clk);
      #1;
      a_valid_i = 1'b0;
      checkOutput("resumeData", a_data_o, 8'h20);
      checkOutput("resumeSof", a_sof_o, 0);
      a_ready_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("heldValid", a_valid_o, 1);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midResetValid", a_valid_o, 0);
      rstn = 1'b1;
      a_ready_i = 1'b1;

      // Directed vector table, starting from the reset state
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].data, vecs[i].byp, vecs[i].sl, vecs[i].seed);
         checkOutput($sformatf("vec%0dValid", i), a_valid_o, 1);
         checkOutput($sformatf("vec%0dData", i), a_data_o, vecs[i].expData);
         if (vecs[i].chkSof) checkOutput($sformatf("vec%0dSof", i), a_sof_o, vecs[i].expSof);
      end

      // Automatic reseed every two beats
      doReset();
      for (int i = 0; i < 4; i++) begin
         b_valid_i = 1'b1;
         b_data_i  = 8'h00;
         @(posedge clk);
         #1;
         checkOutput($sformatf("frame%0dData", i), b_data_o, frameExp[i]);
         checkOutput($sformatf("frame%0dSof", i), b_sof_o, frameSof[i]);
      end
      b_valid_i = 1'b0;

      // Randomized TX->RX chain
      doReset();
      begin
         logic [7:0] sentQ[$];
         exp_t       txQ[$];
         exp_t       e;
         logic [6:0] mState;
         bit         mFirst;
         bit         txAcc;
         bit         txOut;
         bit         rxOut;
         int         sentCount;
         int         rxCount;
         mState    = 7'h7F;
         mFirst    = 1'b1;
         txAcc     = 1'b1;
         sentCount = 0;
         rxCount   = 0;
         for (int cyc = 0; cyc < 20000 && rxCount < 1000; cyc++) begin
            if (!c_valid_i || txAcc) begin
               c_valid_i = (sentCount < 1000) && ($urandom_range(0, 3) != 0);
               c_data_i  = 8'($urandom);
            end
            d_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            txAcc = c_valid_i & c_ready_o;
            txOut = c_valid_o & d_ready_o;
            rxOut = d_valid_o & d_ready_i;
            if (txOut) begin
               if (txQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL txUnexpected actual=%0h expected=none", c_data_o);
               end else begin
                  e = txQ.pop_front();
                  checkOutput("txData", c_data_o, e.y);
                  checkOutput("txSof", c_sof_o, e.sof);
               end
            end
            if (rxOut) begin
               if (sentQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL rxUnexpected actual=%0h expected=none", d_data_o);
               end else begin
                  checkOutput("rxData", d_data_o, sentQ.pop_front());
               end
               rxCount++;
            end
            if (txAcc) begin
               e.y    = c_data_i ^ modelStream(mState)[7:0];
               e.sof  = mFirst;
               mFirst = 1'b0;
               mState = modelNext(mState);
               txQ.push_back(e);
               sentQ.push_back(c_data_i);
               sentCount++;
            end
            @(posedge clk);
            #1;
         end
         c_valid_i = 1'b0;
         checkOutput("rxCount", rxCount, 1000);
         checkOutput("sentLeft", sentQ.size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
